// File: rtl/fp_norm_round.sv
// Normalize-and-round stage for a single-precision adder: takes the raw sum
// (sign, biased exponent, 28-bit magnitude with G/R/S) and produces an IEEE-754 result.
module fp_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        ovf,
  output logic        unf,
  output logic        zro
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_reg, state_next;

  logic        sign_reg;
  logic [9:0]  exp_reg;
  logic [27:0] mant_reg;
  logic        skip_reg;
  logic [31:0] res_reg;
  logic        ovf_reg, unf_reg, zro_reg;

  logic [4:0]  lead_pos;
  logic [4:0]  shift_amt;
  logic [27:0] norm_mant;

  logic        rnd_inc;
  logic [24:0] rnd_sum;
  logic [22:0] rnd_frac;
  logic [9:0]  rnd_exp;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = NORM;
      end
      NORM:  state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- normalize datapath ----------------
  // Highest set bit wins; only meaningful when bits 27 and 26:0 are not all zero.
  always_comb begin
    lead_pos = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (mant_reg[i]) lead_pos = 5'(i);
    end
  end

  assign shift_amt = 5'd26 - lead_pos;
  assign norm_mant = mant_reg << shift_amt;

  // ---------------- round datapath ----------------
  // Increment is applied at bit 3, so only bits 27:3 take part in the add.
  assign rnd_inc  = mant_reg[2] & (mant_reg[3] | mant_reg[1] | mant_reg[0]);
  assign rnd_sum  = mant_reg[27:3] + {24'd0, rnd_inc};
  assign rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
  assign rnd_exp  = rnd_sum[24] ? exp_reg + 10'd1 : exp_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg <= 1'b0;
      exp_reg  <= 10'd0;
      mant_reg <= 28'd0;
      skip_reg <= 1'b0;
      res_reg  <= 32'd0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      zro_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= in_sign;
            exp_reg  <= {2'b00, in_exp};
            mant_reg <= in_mant;
            skip_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
            zro_reg  <= 1'b0;
          end
        end
        NORM: begin
          if (mant_reg == 28'd0) begin
            sign_reg <= 1'b0;
            zro_reg  <= 1'b1;
            skip_reg <= 1'b1;
          end else if (mant_reg[27]) begin
            // Bit shifted out folds into sticky so rounding still sees it.
            mant_reg <= {1'b0, mant_reg[27:2], mant_reg[1] | mant_reg[0]};
            exp_reg  <= exp_reg + 10'd1;
          end else if ({5'd0, shift_amt} >= exp_reg) begin
            unf_reg  <= 1'b1;
            skip_reg <= 1'b1;
          end else begin
            mant_reg <= norm_mant;
            exp_reg  <= exp_reg - {5'd0, shift_amt};
          end
        end
        ROUND: begin
          if (skip_reg) begin
            res_reg <= {sign_reg, 31'd0};
          end else if (rnd_exp >= 10'd255) begin
            res_reg <= {sign_reg, 8'hFF, 23'd0};
            ovf_reg <= 1'b1;
          end else begin
            res_reg <= {sign_reg, rnd_exp[7:0], rnd_frac};
          end
        end
        default: ;
      endcase
    end
  end

  assign res = res_reg;
  assign ovf = ovf_reg;
  assign unf = unf_reg;
  assign zro = zro_reg;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: scoreboard of expected results, fixed-latency
// handshake checks, backpressure hold and mid-operation reset.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [27:0] in_mant = 28'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        ovf, unf, zro;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;   // {ovf, unf, zro}
  } exp_t;

  exp_t sb[$];

  fp_norm_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf), .unf(unf), .zro(zro)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] xr,
                        input logic [2:0] xf, input int hold);
    exp_t x;
    exp_t got;
    int   n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    x.r = xr; x.f = xf;
    sb.push_back(x);
    @(posedge clk); #1;
    // keep in_valid high with junk operands while busy: must be ignored
    in_sign = ~s; in_exp = 8'hA5; in_mant = 28'h5A5A5A5;
    check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_clr_flags"}, 32'({ovf, unf, zro}), 32'd0);
    check({tag, "_ov_e1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ov_e2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ov_e3"}, 32'(out_valid), 32'd1);
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, "_res"}, res, got.r);
      check({tag, "_flags"}, 32'({ovf, unf, zro}), 32'(got.f));
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check({tag, "_hold_res"}, res, got.r);
        check({tag, "_hold_flg"}, 32'({ovf, unf, zro}), 32'(got.f));
        check({tag, "_hold_rdy"}, 32'({in_ready, out_valid}), 32'b01);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // in_valid was still high on the release edge: nothing may be accepted
    check({tag, "_release"}, 32'({in_ready, out_valid}), 32'b10);
    in_valid = 1'b0;
    $display("[TB] %s: sign=%0b exp=%0d mant=%h -> res=%h ovf=%0b unf=%0b zro=%0b",
             tag, s, e, m, res, ovf, unf, zro);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_async_rdy", 32'({in_ready, out_valid}), 32'b10);
    check("rst_async_res", res, 32'h0);
    check("rst_async_flg", 32'({ovf, unf, zro}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op("carry",      1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000, 0);
    run_op("left",       1'b0, 8'd127, 28'h0400000, 32'h3D800000, 3'b000, 0);
    run_op("rnd_carry",  1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b000, 0);
    run_op("tie_even",   1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b000, 0);
    run_op("tie_odd",    1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b000, 0);
    run_op("sticky_sh",  1'b0, 8'd127, 28'h8000009, 32'h40000001, 3'b000, 0);
    run_op("ovf_carry",  1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b100, 0);
    run_op("ovf_round",  1'b1, 8'd254, 28'h7FFFFFC, 32'hFF800000, 3'b100, 0);
    run_op("max_norm",   1'b0, 8'd254, 28'h4000000, 32'h7F000000, 3'b000, 0);
    run_op("unf_neg",    1'b1, 8'd3,   28'h0400000, 32'h80000000, 3'b010, 0);
    run_op("unf_edge",   1'b0, 8'd4,   28'h0400000, 32'h00000000, 3'b010, 0);
    run_op("min_norm",   1'b0, 8'd5,   28'h0400000, 32'h00800000, 3'b000, 0);
    run_op("zero",       1'b1, 8'd77,  28'h0000000, 32'h00000000, 3'b001, 0);
    run_op("backpress",  1'b1, 8'd130, 28'h4000008, 32'hC1000001, 3'b000, 5);

    // reset while in ROUND: operation must vanish
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h4000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("rst_round_rdy", 32'({in_ready, out_valid}), 32'b10);
    check("rst_round_res", res, 32'h0);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rst_round_noval", 32'({in_ready, out_valid}), 32'b10);
    end
    check("rst_round_sb", 32'(sb.size()), 32'd0);
    $display("[TB] rst_round: operation discarded, in_ready=%0b out_valid=%0b", in_ready, out_valid);

    run_op("recover",    1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
